// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared constants for the branch unit: condition codes,
//               branch-type encodings, NZCV flag bit positions and the
//               branch-unit state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

   // Condition codes
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Branch types: bit 0 selects absolute addressing, bit 1 requests a link
   localparam logic [1:0] BR_REL      = 2'b00;
   localparam logic [1:0] BR_ABS      = 2'b01;
   localparam logic [1:0] BR_REL_LINK = 2'b10;
   localparam logic [1:0] BR_ABS_LINK = 2'b11;

   // Flag bit positions inside the NZCV nibble
   localparam int N_BIT = 3;
   localparam int C_BIT = 2;
   localparam int Z_BIT = 1;
   localparam int V_BIT = 0;

   // Branch unit state encoding
   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   function automatic logic is_absolute(input logic [1:0] br_type);
      return br_type[0];
   endfunction

   function automatic logic is_link(input logic [1:0] br_type);
      return br_type[1];
   endfunction

endpackage : branch_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational condition-code evaluator. Decides
//               whether a 4-bit condition holds for a given NZCV nibble.
// Ports       : flags     in  4  NZCV ([3]=N [2]=C [1]=Z [0]=V)
//               cond      in  4  condition code
//               cond_true out 1  condition satisfied
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
   import branch_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       cond_true
);

   logic n, c, z, v;

   assign n = flags[N_BIT];
   assign c = flags[C_BIT];
   assign z = flags[Z_BIT];
   assign v = flags[V_BIT];

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_EQ: cond_true = z;
         COND_NE: cond_true = ~z;
         COND_CS: cond_true = c;
         COND_CC: cond_true = ~c;
         COND_MI: cond_true = n;
         COND_PL: cond_true = ~n;
         COND_VS: cond_true = v;
         COND_VC: cond_true = ~v;
         COND_HI: cond_true = c & ~z;
         COND_LS: cond_true = ~c | z;
         COND_GE: cond_true = (n == v);
         COND_LT: cond_true = (n != v);
         COND_GT: cond_true = ~z & (n == v);
         COND_LE: cond_true = z | (n != v);
         COND_AL: cond_true = 1'b1;
         COND_NV: cond_true = 1'b0;
         default: cond_true = 1'b0;
      endcase
   end

endmodule : cond_eval
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : Latches NZCV flags from execute, evaluates branch
//               conditions against the latched flags, owns the PC and
//               sequences a fetch/decode flush after every taken branch.
// Ports       : clk        in  1   system clock
//               rst_n      in  1   synchronous active-low reset
//               flags_in   in  4   NZCV from execute
//               set_flags  in  1   load flags_in into flags_q
//               stall      in  1   hold all state this cycle
//               br_valid   in  1   branch present this cycle
//               br_cond    in  4   condition code
//               br_type    in  2   00 rel, 01 abs, 10 rel+link, 11 abs+link
//               br_offset  in  24  signed word offset (relative)
//               br_target  in  32  register target (absolute)
//               pc         out 32  current PC
//               flags_q    out 4   registered NZCV
//               br_taken   out 1   branch accepted and condition true
//               flush      out 1   fetch/decode kill
//               link_we    out 1   link-register write strobe
//               link_data  out 32  return address
//               align_err  out 1   misaligned absolute target pulse
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit
   import branch_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned PC_STEP      = 4,
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  flags_in,
   input  logic        set_flags,
   input  logic        stall,
   input  logic        br_valid,
   input  logic [3:0]  br_cond,
   input  logic [1:0]  br_type,
   input  logic [23:0] br_offset,
   input  logic [31:0] br_target,
   output logic [31:0] pc,
   output logic [3:0]  flags_q,
   output logic        br_taken,
   output logic        flush,
   output logic        link_we,
   output logic [31:0] link_data,
   output logic        align_err
);

   localparam logic [31:0] PC_INC     = 32'(PC_STEP);
   localparam logic [2:0]  CNT_INIT   = 3'(FLUSH_CYCLES - 1);
   // A single-cycle flush is just a pulse from RUN; no FLUSH state needed.
   localparam logic        MULTI_CYC  = (FLUSH_CYCLES > 1);

   logic [0:0]  state_q;
   logic [2:0]  cnt_q;
   logic [31:0] pc_q;
   logic [31:0] pc_seq;
   logic [31:0] rel_off;
   logic [31:0] target;
   logic        cond_true;

   cond_eval u_cond_eval (
      .flags     (flags_q),
      .cond      (br_cond),
      .cond_true (cond_true)
   );

   // Word offset, sign-extended and scaled to bytes in one concatenation.
   assign rel_off = {{6{br_offset[23]}}, br_offset, 2'b00};
   assign pc_seq  = pc_q + PC_INC;
   assign target  = is_absolute(br_type) ? {br_target[31:2], 2'b00}
                                         : pc_q + rel_off;

   assign br_taken = (state_q == ST_RUN) & br_valid & ~stall & cond_true;
   assign pc       = pc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         flags_q   <= 4'h0;
         state_q   <= ST_RUN;
         cnt_q     <= 3'd0;
         flush     <= 1'b0;
         link_we   <= 1'b0;
         link_data <= 32'h0;
         align_err <= 1'b0;
      end else if (stall) begin
         // Strobes are single-cycle events; everything else freezes.
         link_we   <= 1'b0;
         align_err <= 1'b0;
      end else begin
         link_we   <= 1'b0;
         align_err <= 1'b0;
         // Branch evaluation above used the old flags_q; update afterwards.
         if (set_flags) begin
            flags_q <= flags_in;
         end
         case (state_q)
            ST_RUN: begin
               if (br_taken) begin
                  pc_q    <= target;
                  flush   <= 1'b1;
                  cnt_q   <= CNT_INIT;
                  state_q <= MULTI_CYC ? ST_FLUSH : ST_RUN;
                  if (is_link(br_type)) begin
                     link_we   <= 1'b1;
                     link_data <= pc_seq;
                  end
                  if (is_absolute(br_type) && (br_target[1:0] != 2'b00)) begin
                     align_err <= 1'b1;
                  end
               end else begin
                  pc_q  <= pc_seq;
                  flush <= 1'b0;
               end
            end
            ST_FLUSH: begin
               pc_q <= pc_seq;
               if (cnt_q == 3'd0) begin
                  state_q <= ST_RUN;
                  flush   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: begin
               state_q <= ST_RUN;
               flush   <= 1'b0;
            end
         endcase
      end
   end

endmodule : branch_unit
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_unit
// Description : Self-checking bench for branch_unit (RESET_PC=0x100,
//               PC_STEP=4, FLUSH_CYCLES=3). Directed sequences, a table of
//               per-condition truth masks, and randomized traffic compared
//               against a behavioural model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam int          FC  = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  flags_in;
   logic        set_flags;
   logic        stall;
   logic        br_valid;
   logic [3:0]  br_cond;
   logic [1:0]  br_type;
   logic [23:0] br_offset;
   logic [31:0] br_target;
   logic [31:0] pc;
   logic [3:0]  flags_q;
   logic        br_taken;
   logic        flush;
   logic        link_we;
   logic [31:0] link_data;
   logic        align_err;

   int checks = 0;
   int errors = 0;

   always #50 clk = ~clk;

   branch_unit #(
      .RESET_PC     (RPC),
      .PC_STEP      (4),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flags_in  (flags_in),
      .set_flags (set_flags),
      .stall     (stall),
      .br_valid  (br_valid),
      .br_cond   (br_cond),
      .br_type   (br_type),
      .br_offset (br_offset),
      .br_target (br_target),
      .pc        (pc),
      .flags_q   (flags_q),
      .br_taken  (br_taken),
      .flush     (flush),
      .link_we   (link_we),
      .link_data (link_data),
      .align_err (align_err)
   );

   // ---------------- reference model ----------------
   bit          m_init = 0;
   logic [31:0] m_pc;
   logic [3:0]  m_flags;
   int          m_rem;        // flush cycles still owed
   bit          m_lwe, m_ae;
   logic [31:0] m_ld;

   // Even codes name a predicate, odd codes are its negation (AL/NV too).
   function automatic bit m_cond(input logic [3:0] f, input logic [3:0] c);
      bit n, cf, z, v, base;
      n = f[3]; cf = f[2]; z = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   function automatic bit m_blocked();
      return (FC > 1) && (m_rem > 0);
   endfunction

   function automatic bit m_taken();
      return !m_blocked() && br_valid && !stall && m_cond(m_flags, br_cond);
   endfunction

   task automatic model_edge();
      bit          tk;
      logic [31:0] off;
      if (!rst_n) begin
         m_init = 1; m_pc = RPC; m_flags = 4'h0; m_rem = 0;
         m_lwe = 0; m_ae = 0; m_ld = 32'h0;
      end else if (stall) begin
         m_lwe = 0; m_ae = 0;
      end else begin
         tk = m_taken();
         m_lwe = 0; m_ae = 0;
         if (set_flags) m_flags = flags_in;
         if (tk) begin
            if (br_type[1]) begin
               m_lwe = 1; m_ld = m_pc + 32'd4;
            end
            if (br_type[0]) begin
               m_ae = (br_target % 4) != 0;
               m_pc = br_target - (br_target % 4);
            end else begin
               off  = {{8{br_offset[23]}}, br_offset};
               m_pc = m_pc + off * 32'd4;
            end
            m_rem = FC;
         end else begin
            m_pc = m_pc + 32'd4;
            if (m_rem > 0) m_rem--;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic tick();
      #1;
      if (m_init) chk("br_taken", 32'(br_taken), 32'(m_taken()));
      @(posedge clk);
      model_edge();
      #1;
      chk("pc", pc, m_pc);
      chk("flags_q", 32'(flags_q), 32'(m_flags));
      chk("flush", 32'(flush), 32'(m_rem > 0));
      chk("link_we", 32'(link_we), 32'(m_lwe));
      chk("link_data", link_data, m_ld);
      chk("align_err", 32'(align_err), 32'(m_ae));
      @(negedge clk);
   endtask

   task automatic idle();
      rst_n = 1; flags_in = 4'h0; set_flags = 0; stall = 0; br_valid = 0;
      br_cond = 4'hE; br_type = 2'b00; br_offset = 24'h0; br_target = 32'h0;
   endtask

   task automatic branch(input logic [3:0] c, input logic [1:0] t,
                         input logic [23:0] off, input logic [31:0] tgt);
      idle();
      br_valid = 1; br_cond = c; br_type = t; br_offset = off; br_target = tgt;
   endtask

   typedef struct {
      logic [3:0]  cond;
      logic [15:0] mask;   // bit f set -> taken when flags_q == f
   } cond_vec_t;
   cond_vec_t tbl[16];

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{4'h0, 16'hCCCC}; tbl[1]  = '{4'h1, 16'h3333};
      tbl[2]  = '{4'h2, 16'hF0F0}; tbl[3]  = '{4'h3, 16'h0F0F};
      tbl[4]  = '{4'h4, 16'hFF00}; tbl[5]  = '{4'h5, 16'h00FF};
      tbl[6]  = '{4'h6, 16'hAAAA}; tbl[7]  = '{4'h7, 16'h5555};
      tbl[8]  = '{4'h8, 16'h3030}; tbl[9]  = '{4'h9, 16'hCFCF};
      tbl[10] = '{4'hA, 16'hAA55}; tbl[11] = '{4'hB, 16'h55AA};
      tbl[12] = '{4'hC, 16'h2211}; tbl[13] = '{4'hD, 16'hDDEE};
      tbl[14] = '{4'hE, 16'hFFFF}; tbl[15] = '{4'hF, 16'h0000};

      idle();
      rst_n = 0;
      @(negedge clk);
      tick();
      chk("reset pc", pc, 32'h100);
      chk("reset flags", 32'(flags_q), 32'h0);
      chk("reset flush", 32'(flush), 32'h0);
      idle(); tick(); chk("run pc1", pc, 32'h104);
      tick(); chk("run pc2", pc, 32'h108);
      tick(); chk("run pc3", pc, 32'h10C);

      // Absolute jump to 0x4, flush walks pc up to 0x10
      branch(4'hE, 2'b01, 24'h0, 32'h4); tick();
      chk("abs pc", pc, 32'h4); chk("abs flush", 32'(flush), 32'h1);
      branch(4'hE, 2'b00, 24'h40, 32'h0);   // ignored while flushing
      #1 chk("ignored in flush", 32'(br_taken), 32'h0);
      tick(); chk("flush pc8", pc, 32'h8);
      idle(); tick(); chk("flush pcC", pc, 32'hC);
      idle(); set_flags = 1; flags_in = 4'b0010; tick();
      chk("pc10", pc, 32'h10); chk("flush off", 32'(flush), 32'h0);
      chk("flags set in flush", 32'(flags_q), 32'h2);

      // EQ relative +4 words at 0x10
      branch(4'h0, 2'b00, 24'd4, 32'h0);
      #1 chk("eq taken", 32'(br_taken), 32'h1);
      tick(); chk("eq target", pc, 32'h20); chk("eq flush", 32'(flush), 32'h1);
      idle(); tick(); chk("flush c2", 32'(flush), 32'h1);
      tick(); chk("flush c3", 32'(flush), 32'h1);
      tick(); chk("flush end", 32'(flush), 32'h0); chk("pc2C", pc, 32'h2C);

      // Same-cycle set_flags and branch: branch sees old Z=0
      idle(); set_flags = 1; flags_in = 4'h0; tick();
      branch(4'h0, 2'b00, 24'd4, 32'h0); set_flags = 1; flags_in = 4'b0010;
      #1 chk("old flags", 32'(br_taken), 32'h0);
      tick(); chk("nt pc", pc, 32'h34); chk("new flags", 32'(flags_q), 32'h2);

      // Absolute+link, misaligned target, at pc 0x40
      idle(); tick(); tick(); tick();
      chk("pc40", pc, 32'h40);
      branch(4'hE, 2'b11, 24'h0, 32'h2003); tick();
      chk("bl pc", pc, 32'h2000); chk("bl we", 32'(link_we), 32'h1);
      chk("bl data", link_data, 32'h44); chk("bl align", 32'(align_err), 32'h1);
      idle(); tick();
      chk("we pulse", 32'(link_we), 32'h0); chk("align pulse", 32'(align_err), 32'h0);
      tick(); tick();

      // Wrap-around, then stall inside FLUSH
      branch(4'hE, 2'b01, 24'h0, 32'hFFFF_FFF4); tick();
      idle(); tick(); tick(); tick();
      chk("pc0", pc, 32'h0);
      branch(4'hE, 2'b00, 24'hFF_FFFF, 32'h0); tick();
      chk("wrap pc", pc, 32'hFFFF_FFFC);
      idle(); stall = 1; set_flags = 1; flags_in = 4'hF; tick();
      chk("stall pc", pc, 32'hFFFF_FFFC); chk("stall flush", 32'(flush), 32'h1);
      chk("stall flags", 32'(flags_q), 32'h2);
      tick(); chk("stall pc2", pc, 32'hFFFF_FFFC);
      idle(); tick(); chk("resume pc", pc, 32'h0); chk("resume flush", 32'(flush), 32'h1);
      tick(); chk("resume flush2", 32'(flush), 32'h1);
      tick(); chk("resume end", 32'(flush), 32'h0); chk("resume pc8", pc, 32'h8);

      // Reset in the middle of FLUSH
      branch(4'hE, 2'b00, 24'd16, 32'h0); tick();
      idle(); tick();
      rst_n = 0; tick();
      chk("mid rst pc", pc, RPC); chk("mid rst flush", 32'(flush), 32'h0);
      branch(4'hE, 2'b00, 24'd2, 32'h0);
      #1 chk("run after rst", 32'(br_taken), 32'h1);
      tick(); chk("post rst br", pc, 32'h108);
      idle(); tick(); tick(); tick();

      // Condition sweep: all 16 flag values x all 16 codes
      for (int f = 0; f < 16; f++) begin
         idle(); set_flags = 1; flags_in = 4'(f); tick();
         idle();
         for (int k = 0; k < 16; k++) begin
            br_valid = 1; br_cond = tbl[k].cond;
            #1;
            chk($sformatf("sweep f%0d c%0d", f, k), 32'(br_taken), 32'(tbl[k].mask[f]));
            br_valid = 0;
            #1;
         end
         tick();
      end

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         stall     = ($urandom_range(0, 4) == 0);
         set_flags = $urandom_range(0, 1);
         flags_in  = 4'($urandom);
         br_valid  = ($urandom_range(0, 9) < 7);
         br_cond   = 4'($urandom);
         br_type   = 2'($urandom);
         br_offset = 24'($urandom);
         br_target = $urandom;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_branch_unit
`default_nettype wire
